instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage on the requesting side of the Program_Mem read port. Drives pc, captures
//   ir one cycle later and hands instructions with their addresses to decode through a
//   valid/ready handshake. Handles jump redirects, decode back-pressure and an optional
//   program-end limit.
// PARAMETERS
//   PC_WIDTH   8    width of pc / jump address / tag
//   DataWidth  16   instruction width (matches Program_Mem ir)
//   CMD_CNT    64   number of valid program words; used only with FETCH_PC_LIMIT_EN
// PORTS
//   clk          in   1          rising-edge clock
//   res_n        in   1          asynchronous active-low reset
//   pc           out  PC_WIDTH   address to Program_Mem (sampled there at each clk edge)
//   ir           in   DataWidth  Program_Mem data, valid the cycle after pc sampled
//   instr_out    out  DataWidth  instruction to decode
//   instr_pc     out  PC_WIDTH   address of instr_out
//   instr_valid  out  1          instr_out/instr_pc valid
//   instr_ready  in   1          decode accepts; transfer = instr_valid & instr_ready
//   jmp_en       in   1          redirect request (1-cycle pulse from execute)
//   jmp_addr     in   PC_WIDTH   redirect target
//   pc_limit     out  1          sticky: fetch stopped at CMD_CNT (0 when macro undefined)
// BEHAVIOUR
//   Reset (async, res_n=0): pc=0, instr_out=0, instr_pc=0, instr_valid=0, pc_limit=0,
//     buffer count=0, inflight=0. Reset mid-operation discards all in-flight/buffered words.
//   Datapath: pc register; inflight flag + tag (address Program_Mem is returning);
//     2-entry FIFO {instr, pc} whose head drives instr_out/instr_pc/instr_valid.
//   Per edge, no jmp_en:
//     pop   = instr_valid & instr_ready (head leaves)
//     push  = inflight (ir captured with its tag into FIFO tail)
//     issue = (count - pop + inflight) <= 1, and not limit-stopped
//     issue: inflight<=1, tag<=pc, pc<=pc+1; else inflight<=0, pc holds.
//   Latency: first edge after reset release issues pc=0; instr_valid=1 after the second
//     edge, with instr_out=ir(0). Throughput 1 instr/cycle while instr_ready=1.
//   Back-pressure: ready low -> FIFO fills to 2, issue stops, pc holds. A word is never
//     dropped or duplicated, and at most 2 words (FIFO + inflight) are held.
//   Redirect (jmp_en=1 at an edge; priority over everything): FIFO count<=0, inflight<=0,
//     instr_valid<=0, pc<=jmp_addr, pc_limit<=0. No issue on that edge.
//     Next edge issues jmp_addr; the target instruction is valid 2 edges after the jump edge.
//     A same-cycle transfer still counts as consumed by decode. ir returning that cycle is discarded.
//   Wrap: pc+1 wraps modulo 2^PC_WIDTH (0xFF -> 0x00) when the macro is undefined.
//   Empty FIFO: instr_valid=0, instr_out/instr_pc hold their last value (0 after reset).
// CONFIGURATION
//   FETCH_PC_LIMIT_EN defined: issue is blocked when pc >= CMD_CNT.
//     pc_limit <= 1 at the first blocked edge and stays set until jmp_en or reset.
//     Already-fetched words still drain normally. A jmp to an address >= CMD_CNT sets pc_limit on the next edge.
//   FETCH_PC_LIMIT_EN undefined: no limit check, pc wraps, pc_limit tied 0.
// TESTING (with Program_Mem, default image)
//   1 Reset, res_n=1, ready=1 -> after edge 2: instr_valid=1, instr_out=16'h4903, instr_pc=0;
//     next cycles 16'h4A14 (pc 1), 16'h4BF0 (pc 2), 16'h0910 (pc 3), one per cycle.
//   2 ready=0 from pc1 output for 5 cycles -> pc stops at 3, instr_out holds 16'h4A14.
//     Release -> 16'h4BF0, 16'h0910, 16'h1918 in order, no gaps or repeats.
//   3 jmp_en with jmp_addr=10 while pc 4 is in flight -> instr_valid=0 for 2 cycles,
//     then instr_out=16'h8008, instr_pc=10. pc 4/5 never presented to decode.
//   4 jmp_en with a simultaneous transfer, and a jmp while FIFO is full -> FIFO empty next
//     cycle, no stale word after the target.
//   5 res_n=0 mid-stream with FIFO full -> all outputs 0 asynchronously. After release,
//     sequence restarts at pc 0 as in test 1.
//   6 Macro defined, CMD_CNT=8, jmp to 6 -> pc 6 and 7 delivered, then pc_limit=1 and
//     instr_valid=0 persist. jmp to 0 clears pc_limit. Macro undefined: jmp 0xFE -> pc 0xFE, 0xFF, 0x00.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: pc issue, 2-entry {instr,pc} buffer, jump redirect
// Optional program-end stop enabled with FETCH_PC_LIMIT_EN.
module instr_fetch_unit #(
  parameter int PC_WIDTH  = 8,
  parameter int DataWidth = 16,
  parameter int CMD_CNT   = 64
) (
  input  logic                 clk,
  input  logic                 res_n,
  output logic [PC_WIDTH-1:0]  pc,
  input  logic [DataWidth-1:0] ir,
  output logic [DataWidth-1:0] instr_out,
  output logic [PC_WIDTH-1:0]  instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 jmp_en,
  input  logic [PC_WIDTH-1:0]  jmp_addr,
  output logic                 pc_limit
);

  logic [1:0]           count;
  logic                 inflight;
  logic [PC_WIDTH-1:0]  tag;
  logic [DataWidth-1:0] tail_instr;
  logic [PC_WIDTH-1:0]  tail_pc;

  logic       pop;
  logic [1:0] after_pop;
  logic [2:0] occupancy;
  logic       blocked;
  logic       issue;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign after_pop   = count - {1'b0, pop};
  assign occupancy   = {1'b0, after_pop} + {2'b00, inflight};

`ifdef FETCH_PC_LIMIT_EN
  localparam logic [PC_WIDTH:0] LIMIT = (PC_WIDTH + 1)'(CMD_CNT);
  logic limit_q;
  assign blocked  = ({1'b0, pc} >= LIMIT);
  assign pc_limit = limit_q;
`else
  assign blocked  = 1'b0;
  assign pc_limit = 1'b0;
`endif

  // Issue only if the returning word and this new request both still fit in the buffer.
  assign issue = (occupancy <= 3'd1) && !blocked;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pc         <= '0;
      count      <= 2'd0;
      inflight   <= 1'b0;
      tag        <= '0;
      instr_out  <= '0;
      instr_pc   <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
`ifdef FETCH_PC_LIMIT_EN
      limit_q    <= 1'b0;
`endif
    end else if (jmp_en) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      pc       <= jmp_addr;
`ifdef FETCH_PC_LIMIT_EN
      limit_q  <= 1'b0;
`endif
    end else begin
      if (pop && count == 2'd2) begin
        instr_out <= tail_instr;
        instr_pc  <= tail_pc;
      end
      if (inflight) begin
        if (after_pop == 2'd0) begin
          instr_out <= ir;
          instr_pc  <= tag;
        end else begin
          tail_instr <= ir;
          tail_pc    <= tag;
        end
      end
      count    <= after_pop + {1'b0, inflight};
      inflight <= issue;
      if (issue) begin
        tag <= pc;
        pc  <= pc + PC_WIDTH'(1);
      end
`ifdef FETCH_PC_LIMIT_EN
      if (blocked) limit_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven bench for instr_fetch_unit with a Program_Mem model
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        res_n;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp_en;
  logic [7:0]  jmp_addr;
  logic        pc_limit;

  int vectors_applied = 0;
  int miscompares     = 0;

  instr_fetch_unit #(.PC_WIDTH(8), .DataWidth(16), .CMD_CNT(64)) dut (
    .clk(clk), .res_n(res_n), .pc(pc), .ir(ir),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pc_limit(pc_limit)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    case (a)
      8'd0:    return 16'h4903;
      8'd1:    return 16'h4A14;
      8'd2:    return 16'h4BF0;
      8'd3:    return 16'h0910;
      8'd4:    return 16'h1918;
      8'd10:   return 16'h8008;
      default: return {8'hC0, a};
    endcase
  endfunction

  // Program_Mem: registered read of the address presented at the edge.
  always @(posedge clk) ir <= mem_word(pc);

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        jmp;
    logic [7:0]  jaddr;
    logic        exp_valid;
    logic [15:0] exp_out;
    logic [7:0]  exp_ipc;
    logic [7:0]  exp_pc;
    logic        exp_lim;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic jmp,
                              input logic [7:0] jaddr, input logic ev,
                              input logic [15:0] eo, input logic [7:0] eipc,
                              input logic [7:0] epc, input logic el);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.jmp = jmp; t.jaddr = jaddr;
    t.exp_valid = ev; t.exp_out = eo; t.exp_ipc = eipc; t.exp_pc = epc; t.exp_lim = el;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, got, exp);
    end
  endtask

  // Assert reset away from the clock edge so the clear must be asynchronous.
  task automatic do_reset(input int idx);
    res_n = 1'b0;
    #1;
    vectors_applied++;
    chk("rst_pc", idx, {8'h00, pc}, 16'h0000);
    chk("rst_instr_out", idx, instr_out, 16'h0000);
    chk("rst_instr_pc", idx, {8'h00, instr_pc}, 16'h0000);
    chk("rst_valid", idx, {15'd0, instr_valid}, 16'h0000);
    chk("rst_pc_limit", idx, {15'd0, pc_limit}, 16'h0000);
    repeat (2) @(negedge clk);
    res_n = 1'b1;
  endtask

  initial begin
    res_n = 1'b1; instr_ready = 1'b1; jmp_en = 1'b0; jmp_addr = 8'h00;

    // Startup, back-pressure hold and release.
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h01, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4903, 8'h00, 8'h02, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4A14, 8'h01, 8'h03, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'h4A14, 8'h01, 8'h03, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4BF0, 8'h02, 8'h04, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h0910, 8'h03, 8'h05, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h1918, 8'h04, 8'h06, 0));
    // Jump to 10 with pc 4 in flight.
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h01, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4903, 8'h00, 8'h02, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4A14, 8'h01, 8'h03, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4BF0, 8'h02, 8'h04, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h0910, 8'h03, 8'h05, 0));
    vecs.push_back(mk(0, 1, 1, 8'h0A, 0, 16'h0910, 8'h03, 8'h0A, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0910, 8'h03, 8'h0B, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h8008, 8'h0A, 8'h0C, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC00B, 8'h0B, 8'h0D, 0));
    // Jump coinciding with a transfer, then a jump with the buffer full.
    vecs.push_back(mk(0, 1, 1, 8'h14, 0, 16'hC00B, 8'h0B, 8'h14, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'hC00B, 8'h0B, 8'h15, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC014, 8'h14, 8'h16, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'hC014, 8'h14, 8'h16, 0));
    vecs.push_back(mk(0, 0, 1, 8'h1E, 0, 16'hC014, 8'h14, 8'h1E, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'hC014, 8'h14, 8'h1F, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC01E, 8'h1E, 8'h20, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC01F, 8'h1F, 8'h21, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'hC01F, 8'h1F, 8'h21, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'hC01F, 8'h1F, 8'h21, 0));
    // Reset with the buffer full, restart from pc 0.
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 8'h01, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4903, 8'h00, 8'h02, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4A14, 8'h01, 8'h03, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4BF0, 8'h02, 8'h04, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h0910, 8'h03, 8'h05, 0));
`ifdef FETCH_PC_LIMIT_EN
    // Program end at 64: 62 and 63 delivered, then sticky stop until a jump.
    vecs.push_back(mk(0, 1, 1, 8'h3E, 0, 16'h0910, 8'h03, 8'h3E, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0910, 8'h03, 8'h3F, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC03E, 8'h3E, 8'h40, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC03F, 8'h3F, 8'h40, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'hC03F, 8'h3F, 8'h40, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'hC03F, 8'h3F, 8'h40, 1));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 16'hC03F, 8'h3F, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'hC03F, 8'h3F, 8'h01, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4903, 8'h00, 8'h02, 0));
`else
    // pc wraps 0xFF -> 0x00.
    vecs.push_back(mk(0, 1, 1, 8'hFE, 0, 16'h0910, 8'h03, 8'hFE, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h0910, 8'h03, 8'hFF, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC0FE, 8'hFE, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'hC0FF, 8'hFF, 8'h01, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h4903, 8'h00, 8'h02, 0));
`endif

    #3;
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset(i);
      instr_ready = vecs[i].rdy;
      jmp_en      = vecs[i].jmp;
      jmp_addr    = vecs[i].jaddr;
      @(posedge clk);
      #1;
      vectors_applied++;
      chk("instr_valid", i, {15'd0, instr_valid}, {15'd0, vecs[i].exp_valid});
      chk("instr_out", i, instr_out, vecs[i].exp_out);
      chk("instr_pc", i, {8'h00, instr_pc}, {8'h00, vecs[i].exp_ipc});
      chk("pc", i, {8'h00, pc}, {8'h00, vecs[i].exp_pc});
      chk("pc_limit", i, {15'd0, pc_limit}, {15'd0, vecs[i].exp_lim});
      @(negedge clk);
    end
    jmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
